// File: rtl/bram_pkg.sv
// Shared BRAM geometry defaults and the fill/read FSM state encoding.
// Used by both the stream loader and the read-side controller.
package bram_pkg;
  localparam int BRAM_DWIDTH   = 8;
  localparam int BRAM_AWIDTH   = 12;
  localparam int BRAM_MEM_SIZE = 3840;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/wrap_addr_counter.sv
// Loadable BRAM address counter that wraps at MEM_SIZE (not a power of two).
// Load/increment take effect at the next clock; no backpressure of its own.
module wrap_addr_counter import bram_pkg::*; #(
  parameter int AWIDTH   = BRAM_AWIDTH,
  parameter int MEM_SIZE = BRAM_MEM_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [AWIDTH-1:0] i_load_val,
  input  logic              i_inc,
  output logic [AWIDTH-1:0] o_addr
);
  localparam logic [AWIDTH:0] LP_SIZE = (AWIDTH+1)'(MEM_SIZE);

  logic [AWIDTH-1:0] r_addr;
  logic [AWIDTH:0]   w_sum;
  logic [AWIDTH:0]   w_wrapped;

  // One extra bit so the compare-and-subtract sees the carry past MEM_SIZE-1.
  assign w_sum     = {1'b0, r_addr} + (AWIDTH+1)'(1);
  assign w_wrapped = (w_sum >= LP_SIZE) ? (w_sum - LP_SIZE) : w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_inc) begin
      r_addr <= w_wrapped[AWIDTH-1:0];
    end
  end

  assign o_addr = r_addr;
endmodule

// File: rtl/bram_stream_loader.sv
// Writes a valid/ready byte stream sequentially into a BRAM port from a base address, wrapping at MEM_SIZE.
// Beat in cycle k hits the BRAM in k+1, done in k+2 after the last beat; s_ready only in FILL, stalls on s_valid low.
module bram_stream_loader import bram_pkg::*; #(
  parameter int DWIDTH   = BRAM_DWIDTH,
  parameter int AWIDTH   = BRAM_AWIDTH,
  parameter int MEM_SIZE = BRAM_MEM_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   length,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_last,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_d
);
  logic [1:0]        r_state;
  logic [AWIDTH:0]   r_count;
  logic [AWIDTH:0]   r_len;
  logic              r_err;
  logic              r_mem_ce;
  logic [AWIDTH-1:0] r_mem_addr;
  logic [DWIDTH-1:0] r_mem_d;

  logic              w_start_acc;
  logic              w_beat;
  logic              w_final;
  logic [AWIDTH:0]   w_count_inc;
  logic [AWIDTH-1:0] w_addr;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_beat      = (r_state == S_FILL) && s_valid;
  assign w_count_inc = r_count + (AWIDTH+1)'(1);
  assign w_final     = (w_count_inc == r_len);

  wrap_addr_counter #(
    .AWIDTH   (AWIDTH),
    .MEM_SIZE (MEM_SIZE)
  ) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start_acc),
    .i_load_val (base_addr),
    .i_inc      (w_beat),
    .o_addr     (w_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_mem_ce   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_d    <= '0;
    end else begin
      r_mem_ce <= w_beat;
      if (w_beat) begin
        r_mem_addr <= w_addr;
        r_mem_d    <= s_data;
        r_count    <= w_count_inc;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= length;
            r_count <= '0;
            r_err   <= 1'b0;
            r_state <= (length == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          // Either the count ends the frame or s_last does; disagreement is a framing error.
          if (w_beat && (w_final || s_last)) begin
            r_state <= S_DRAIN;
            if (w_final ^ s_last) r_err <= 1'b1;
          end
        end
        S_DRAIN: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign s_ready  = (r_state == S_FILL);
  assign err      = r_err;
  assign mem_ce   = r_mem_ce;
  assign mem_we   = r_mem_ce;
  assign mem_addr = r_mem_addr;
  assign mem_d    = r_mem_d;
endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench for bram_stream_loader: fills, wrap, framing errors, stalls, zero length, mid-fill reset.
module tb_bram_stream_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0;
  logic        busy, done, err;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_ce, mem_we;
  logic [7:0]  mem_d;

  bram_stream_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we), .mem_d(mem_d)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int done_cyc = 0;
  int n_cewe_bad = 0;
  logic [7:0] ram [0:4095];
  bit busy_hist [0:4095];
  bit rdy_hist  [0:4095];
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];

  int start_cyc, last_cyc, n_acc, d0;
  bit saw_done;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model and output history, sampled away from the active edge.
  always @(negedge clk) begin
    if (cyc < 4096) begin
      busy_hist[cyc] <= busy;
      rdy_hist[cyc]  <= s_ready;
    end
    if (mem_we) begin
      ram[mem_addr] <= mem_d;
      wq_addr.push_back(int'(mem_addr));
      wq_data.push_back(int'(mem_d));
      wq_cyc.push_back(cyc);
    end
    if (mem_we !== mem_ce) n_cewe_bad <= n_cewe_bad + 1;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic run_fill(input int base, input int len, input int nbytes, input int last_idx,
                          input int seed, input bit gaps, input bit midstart);
    int i;
    int iter;
    bit acc;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    d0 = n_done;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'(base); length = 13'(len);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 0; i = 0; iter = 0; last_cyc = 0;
    while (i < nbytes && !saw_done && iter < 400) begin
      s_valid = !(gaps && $urandom_range(0, 2) == 0);
      s_data  = 8'(seed + i);
      s_last  = (i == last_idx);
      start   = midstart && (i == 3);
      @(negedge clk);
      acc = s_valid && s_ready;
      if (acc) last_cyc = cyc;
      if (done) saw_done = 1;
      @(posedge clk); #1;
      if (acc) i++;
      iter++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    for (int w = 0; w < 20 && !saw_done; w++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    repeat (3) @(posedge clk);
    #1;
    n_acc = i;
  endtask

  task automatic check_fill(input string tag, input int base, input int n, input int seed, input int exp_err);
    int ea;
    check({tag, "_done_seen"}, 32'(saw_done), 32'd1);
    check({tag, "_ndone"}, 32'(n_done - d0), 32'd1);
    check({tag, "_accepted"}, 32'(n_acc), 32'(n));
    check({tag, "_nwrites"}, 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      ea = (base + i) % 3840;
      check({tag, "_addr"}, 32'(wq_addr[i]), 32'(ea));
      check({tag, "_data"}, 32'(wq_data[i]), 32'((seed + i) & 255));
      check({tag, "_ram"}, 32'(ram[ea]), 32'((seed + i) & 255));
    end
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(last_cyc + 2));
    check({tag, "_busy_fall"}, {30'd0, busy_hist[last_cyc + 2], busy_hist[last_cyc + 3]}, 32'd2);
    check({tag, "_busy_rise"}, {30'd0, busy_hist[start_cyc], busy_hist[start_cyc + 1]}, 32'd1);
    check({tag, "_rdy_rise"}, 32'(rdy_hist[start_cyc + 1]), 32'd1);
    check({tag, "_rdy_drain"}, 32'(rdy_hist[last_cyc + 1]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_we", {30'd0, mem_ce, mem_we}, 32'd0);
    check("rst_mem", {12'd0, mem_addr, mem_d}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Plain fill of 16 bytes with no stalls: writes must be back to back.
    run_fill(0, 16, 16, 15, 0, 1'b0, 1'b0);
    check_fill("fill", 0, 16, 0, 0);
    if (wq_cyc.size() == 16)
      check("fill_consec", 32'(wq_cyc[15] - wq_cyc[0]), 32'd15);
    check("fill_first_wr", 32'(wq_cyc.size() > 0 ? wq_cyc[0] : -1), 32'(start_cyc + 2));

    // Wrap past MEM_SIZE-1 back to 0.
    run_fill(3836, 8, 8, 7, 8'h40, 1'b0, 1'b0);
    check_fill("wrap", 3836, 8, 8'h40, 0);

    // Early s_last on beat 6 of 10.
    run_fill(50, 10, 10, 5, 8'h80, 1'b0, 1'b0);
    check_fill("early", 50, 6, 8'h80, 1);

    // No s_last at all: the fifth offered byte must stay unconsumed.
    run_fill(300, 4, 5, -1, 8'hC0, 1'b0, 1'b0);
    check_fill("nolast", 300, 4, 8'hC0, 1);

    // Random valid gaps with a start pulse mid-fill; err from the previous run must clear.
    run_fill(2000, 12, 12, 11, 8'h11, 1'b1, 1'b1);
    check_fill("gaps", 2000, 12, 8'h11, 0);

    // Zero length: done the cycle after start, no write.
    run_fill(5, 0, 0, -1, 0, 1'b0, 1'b0);
    check("len0_done_seen", 32'(saw_done), 32'd1);
    check("len0_done_cyc", 32'(done_cyc), 32'(start_cyc + 1));
    check("len0_nwrites", 32'(wq_addr.size()), 32'd0);
    check("len0_err", 32'(err), 32'd0);

    // Reset after 5 of 20 beats, while the fifth write is on the BRAM port.
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'd100; length = 13'd20;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hA0 + i); s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("prerst_we", 32'(mem_we), 32'd1);
    check("prerst_mem", {12'd0, mem_addr, mem_d}, {12'd0, 12'd104, 8'hA4});
    d0 = n_done;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_ready", 32'(s_ready), 32'd0);
    check("arst_we", {30'd0, mem_ce, mem_we}, 32'd0);
    check("arst_mem", {12'd0, mem_addr, mem_d}, 32'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("arst_nodone", 32'(n_done - d0), 32'd0);
    check("arst_nwrites", 32'(wq_addr.size()), 32'd4);

    run_fill(200, 8, 8, 7, 8'h33, 1'b0, 1'b0);
    check_fill("post_rst", 200, 8, 8'h33, 0);

    check("ce_we_equal", 32'(n_cewe_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
